// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trace_pkg
//  Description : Shared types and constants for the CPU trace buffer:
//                serializer states, trace record layout, header bit map.
//  Revision    : 1.0
// ============================================================================
package trace_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         REC_W         = 55;

    // Header word bit map
    localparam int HDR_SYNC_MSB = 15;
    localparam int HDR_SYNC_LSB = 8;
    localparam int HDR_OVF      = 7;
    localparam int HDR_Z        = 6;
    localparam int HDR_BR       = 5;
    localparam int HDR_MR       = 4;
    localparam int HDR_SEQ_MSB  = 3;
    localparam int HDR_SEQ_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_PC   = 3'd2,
        ST_INS  = 3'd3,
        ST_ALU  = 3'd4
    } ser_state_e;

    // 4 + 3 + 16 + 16 + 16 = 55 bits
    typedef struct packed {
        logic [3:0]  seq;
        logic        zero;
        logic        branch;
        logic        mem_read;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] alu;
    } trace_rec_t;

    // Builds the first stream word of a record.
    function automatic logic [15:0] make_header(input logic [7:0] sync,
                                                input logic       ovf,
                                                input trace_rec_t rec);
        logic [15:0] h;
        h                            = '0;
        h[HDR_SYNC_MSB:HDR_SYNC_LSB] = sync;
        h[HDR_OVF]                   = ovf;
        h[HDR_Z]                     = rec.zero;
        h[HDR_BR]                    = rec.branch;
        h[HDR_MR]                    = rec.mem_read;
        h[HDR_SEQ_MSB:HDR_SEQ_LSB]   = rec.seq;
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_trace_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_trace_buffer_if
//  Description : 16-bit valid/ready stream carrying serialized trace words.
//  Revision    : 1.0
// ============================================================================
interface cpu_trace_buffer_if;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (output out_data, output out_valid, input  out_ready);
    modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : trace_fifo
//  Description : Show-ahead synchronous FIFO of trace records. A push while
//                full is accepted only when a pop happens in the same cycle.
//  Revision    : 1.0
// ============================================================================
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = REC_W
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              push,
    input  wire logic [WIDTH-1:0]  push_data,
    input  wire logic              pop,
    output logic      [WIDTH-1:0]  pop_data,
    output logic                   full,
    output logic                   empty,
    output logic      [ADDR_W:0]   level
);

    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q,  level_d;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign full      = (level_q == LVL_FULL);
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign pop_data  = mem_q[rd_ptr_q];
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    // Pointer and level bookkeeping; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (w_pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({w_push_ok, w_pop_ok})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Record storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_trace_buffer
//  Description : Captures one retired-instruction record per enabled cycle,
//                buffers it and streams it out as four 16-bit words
//                (header, PC, instruction, ALU). Never stalls the CPU;
//                records that do not fit are counted as drops.
//  Revision    : 1.0
// ============================================================================
module cpu_trace_buffer
    import trace_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              trace_en,
    input  wire logic [15:0]       pc_in,
    input  wire logic [15:0]       instr_in,
    input  wire logic [15:0]       alu_in,
    input  wire logic              zero_in,
    input  wire logic              branch_in,
    input  wire logic              mem_read_in,
    input  wire logic              clear_stats,
    cpu_trace_buffer_if.master     stream,
    output logic      [ADDR_W:0]   fifo_level,
    output logic                   overflow,
    output logic      [15:0]       drop_count
);

    ser_state_e  state_q, state_d;
    logic [3:0]  seq_q, seq_d;
    logic        overflow_q, overflow_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        pend_q, pend_d;
    trace_rec_t  shadow_q, shadow_d;
    logic        shadow_ovf_q, shadow_ovf_d;

    trace_rec_t       w_rec;
    logic [REC_W-1:0] w_pop_data;
    logic             w_full;
    logic             w_empty;
    logic             w_valid;
    logic             w_hs;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    assign w_rec = '{seq: seq_q, zero: zero_in, branch: branch_in,
                     mem_read: mem_read_in, pc: pc_in, instr: instr_in,
                     alu: alu_in};

    assign w_valid = (state_q != ST_IDLE);
    assign w_hs    = w_valid && stream.out_ready;
    // Pop when idle, or when the last word of a record is accepted
    assign w_pop   = !w_empty && ((state_q == ST_IDLE) ||
                                  ((state_q == ST_ALU) && w_hs));
    assign w_push  = trace_en && (!w_full || w_pop);
    assign w_drop  = trace_en && w_full && !w_pop;

    trace_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (REC_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_rec),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .full      (w_full),
        .empty     (w_empty),
        .level     (fifo_level)
    );

    // Sequence numbering and drop statistics; clear overrides a same-cycle drop
    always_comb begin
        seq_d      = seq_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        pend_d     = pend_q;
        if (w_push) seq_d = seq_q + 4'd1;
        if (w_pop)  pend_d = 1'b0;
        if (w_drop) begin
            overflow_d = 1'b1;
            pend_d     = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (clear_stats) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
            pend_d     = 1'b0;
        end
    end

    // Shadow record being serialized, plus its latched drop flag
    always_comb begin
        shadow_d     = shadow_q;
        shadow_ovf_d = shadow_ovf_q;
        if (w_pop) begin
            shadow_d     = w_pop_data;
            shadow_ovf_d = pend_q;
        end
    end

    // Serializer next state: advance one word per handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!w_empty) state_d = ST_HDR;
            ST_HDR:  if (w_hs)     state_d = ST_PC;
            ST_PC:   if (w_hs)     state_d = ST_INS;
            ST_INS:  if (w_hs)     state_d = ST_ALU;
            ST_ALU:  if (w_hs)     state_d = w_empty ? ST_IDLE : ST_HDR;
            default:               state_d = ST_IDLE;
        endcase
    end

    // Serializer outputs decoded from state and the shadow record
    always_comb begin
        stream.out_valid = w_valid;
        case (state_q)
            ST_HDR:  stream.out_data = make_header(SYNC_BYTE, shadow_ovf_q, shadow_q);
            ST_PC:   stream.out_data = shadow_q.pc;
            ST_INS:  stream.out_data = shadow_q.instr;
            ST_ALU:  stream.out_data = shadow_q.alu;
            default: stream.out_data = '0;
        endcase
    end

    // State, statistics and shadow registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            seq_q        <= '0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
            pend_q       <= 1'b0;
            shadow_q     <= '0;
            shadow_ovf_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
            pend_q       <= pend_d;
            shadow_q     <= shadow_d;
            shadow_ovf_q <= shadow_ovf_d;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_trace_buffer
//  Description : Self-checking bench for cpu_trace_buffer: queue-based
//                reference model compared every cycle, plus directed
//                scenarios with literal expectations.
//  Revision    : 1.0
// ============================================================================
module tb_cpu_trace_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        trace_en = 1'b0;
    logic [15:0] pc_in = '0;
    logic [15:0] instr_in = '0;
    logic [15:0] alu_in = '0;
    logic        zero_in = 1'b0;
    logic        branch_in = 1'b0;
    logic        mem_read_in = 1'b0;
    logic        clear_stats = 1'b0;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [15:0] drop_count;

    cpu_trace_buffer_if sif ();

    cpu_trace_buffer #(
        .DEPTH     (DEPTH),
        .ADDR_W    (4),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trace_en    (trace_en),
        .pc_in       (pc_in),
        .instr_in    (instr_in),
        .alu_in      (alu_in),
        .zero_in     (zero_in),
        .branch_in   (branch_in),
        .mem_read_in (mem_read_in),
        .clear_stats (clear_stats),
        .stream      (sif),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: records in a queue, current record as a word list
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0]  seq;
        logic        z;
        logic        b;
        logic        m;
        logic [15:0] pc;
        logic [15:0] ins;
        logic [15:0] alu;
    } mrec_t;

    mrec_t       mq[$];
    logic [15:0] m_words [4];
    bit          m_busy = 0;
    int          m_idx  = 0;
    int          m_seq  = 0;
    bit          m_pend = 0;
    bit          m_ovf  = 0;
    int          m_cnt  = 0;

    initial forever begin : model
        bit    hs, pop, full, drop;
        mrec_t r;
        @(posedge clk or negedge reset);
        if (!reset) begin
            mq.delete();
            m_busy = 0; m_idx = 0; m_seq = 0;
            m_pend = 0; m_ovf = 0; m_cnt = 0;
        end else begin
            hs   = m_busy && (sif.out_ready === 1'b1);
            full = (mq.size() == DEPTH);
            pop  = (mq.size() > 0) && (!m_busy || (m_idx == 3 && hs));
            drop = trace_en && full && !pop;
            if (hs) begin
                if (m_idx == 3) m_busy = 0;
                else            m_idx++;
            end
            if (pop) begin
                r = mq.pop_front();
                m_words[0] = {8'hA5, m_pend, r.z, r.b, r.m, r.seq};
                m_words[1] = r.pc;
                m_words[2] = r.ins;
                m_words[3] = r.alu;
                m_busy = 1; m_idx = 0; m_pend = 0;
            end
            if (trace_en && !drop) begin
                r.seq = 4'(m_seq);
                r.z = zero_in; r.b = branch_in; r.m = mem_read_in;
                r.pc = pc_in; r.ins = instr_in; r.alu = alu_in;
                mq.push_back(r);
                m_seq = (m_seq + 1) % 16;
            end
            if (drop) begin
                m_pend = 1; m_ovf = 1;
                if (m_cnt < 65535) m_cnt++;
            end
            if (clear_stats) begin
                m_pend = 0; m_ovf = 0; m_cnt = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial forever begin : compare
        @(negedge clk);
        chk("m_valid", 32'(sif.out_valid), 32'(m_busy));
        if (m_busy) chk("m_data", 32'(sif.out_data), 32'(m_words[m_idx]));
        chk("m_level", 32'(fifo_level), 32'(mq.size()));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
        chk("m_drops", 32'(drop_count), 32'(m_cnt));
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        trace_en = 1'b0;
        clear_stats = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic set_rec(input logic [15:0] p, input logic [15:0] i, input logic [15:0] a,
                           input logic z, input logic b, input logic m);
        pc_in = p; instr_in = i; alu_in = a;
        zero_in = z; branch_in = b; mem_read_in = m;
    endtask

    initial begin
        sif.out_ready = 1'b1;
        reset = 1'b0;
        repeat (2) tick();
        chk("rst_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_data", 32'(sif.out_data), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drops", 32'(drop_count), 32'd0);
        reset = 1'b1;
        tick();

        // Single capture
        set_rec(16'h0010, 16'h1234, 16'h0042, 1'b1, 1'b0, 1'b0);
        trace_en = 1'b1;
        tick();
        trace_en = 1'b0;
        chk("single_lat_valid", 32'(sif.out_valid), 32'd0);
        tick(); chk("single_hdr", 32'(sif.out_data), 32'h0000A540);
        chk("single_hdr_valid", 32'(sif.out_valid), 32'd1);
        tick(); chk("single_pc", 32'(sif.out_data), 32'h00000010);
        tick(); chk("single_ins", 32'(sif.out_data), 32'h00001234);
        tick(); chk("single_alu", 32'(sif.out_data), 32'h00000042);
        tick(); chk("single_done", 32'(sif.out_valid), 32'd0);

        // Back-to-back: three records, twelve words without a gap
        do_reset();
        for (int t = 0; t < 14; t++) begin
            trace_en = (t < 3);
            set_rec(16'h0A00 + 16'(t), 16'h0B00 + 16'(t), 16'h0C00 + 16'(t), 1'b0, 1'b0, 1'b0);
            tick();
            if (t >= 1 && t <= 12) begin
                chk("b2b_valid", 32'(sif.out_valid), 32'd1);
                if ((t - 1) % 4 == 0)
                    chk("b2b_hdr", 32'(sif.out_data), 32'h0000A500 + 32'((t - 1) / 4));
            end
            if (t == 13) chk("b2b_end", 32'(sif.out_valid), 32'd0);
        end

        // Backpressure during the PC word
        do_reset();
        set_rec(16'h0010, 16'h1234, 16'h0042, 1'b1, 1'b0, 1'b0);
        trace_en = 1'b1;
        tick();
        trace_en = 1'b0;
        tick(); chk("bp_hdr", 32'(sif.out_data), 32'h0000A540);
        tick(); chk("bp_pc", 32'(sif.out_data), 32'h00000010);
        sif.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold", 32'(sif.out_data), 32'h00000010);
            chk("bp_hold_valid", 32'(sif.out_valid), 32'd1);
        end
        sif.out_ready = 1'b1;
        tick(); chk("bp_ins", 32'(sif.out_data), 32'h00001234);
        tick(); chk("bp_alu", 32'(sif.out_data), 32'h00000042);
        tick(); chk("bp_done", 32'(sif.out_valid), 32'd0);

        // Overflow: 20 captures with the consumer stalled
        do_reset();
        sif.out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            trace_en = 1'b1;
            set_rec(16'h0100 + 16'(k), 16'h0200 + 16'(k), 16'h0300 + 16'(k), 1'b0, 1'b0, 1'b0);
            tick();
        end
        trace_en = 1'b0;
        chk("ovf_level", 32'(fifo_level), 32'd16);
        chk("ovf_drops", 32'(drop_count), 32'd3);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_first_hdr", 32'(sif.out_data), 32'h0000A500);
        sif.out_ready = 1'b1;
        repeat (4) tick();
        chk("ovf_next_hdr", 32'(sif.out_data), 32'h0000A581);
        chk("ovf_level_after_pop", 32'(fifo_level), 32'd15);
        sif.out_ready = 1'b0;

        // clear_stats in the same cycle as a drop
        trace_en = 1'b1;
        set_rec(16'h0500, 16'h0600, 16'h0700, 1'b0, 1'b0, 1'b0);
        tick();
        chk("clr_prefill_level", 32'(fifo_level), 32'd16);
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        trace_en = 1'b0;
        chk("clr_drops", 32'(drop_count), 32'd0);
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_level", 32'(fifo_level), 32'd16);
        sif.out_ready = 1'b1;

        // Reset asserted during the INS word
        do_reset();
        set_rec(16'h0021, 16'h0022, 16'h0023, 1'b0, 1'b0, 1'b0);
        trace_en = 1'b1;
        tick();
        trace_en = 1'b0;
        tick(); tick(); tick();
        chk("rs_ins", 32'(sif.out_data), 32'h00000022);
        #2 reset = 1'b0;
        #1;
        chk("rs_async_valid", 32'(sif.out_valid), 32'd0);
        chk("rs_async_level", 32'(fifo_level), 32'd0);
        tick();
        reset = 1'b1;
        set_rec(16'h0077, 16'h0088, 16'h0099, 1'b0, 1'b1, 1'b1);
        trace_en = 1'b1;
        tick();
        trace_en = 1'b0;
        tick(); chk("rs_new_hdr", 32'(sif.out_data), 32'h0000A530);
        tick(); chk("rs_new_pc", 32'(sif.out_data), 32'h00000077);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Downstream observer of the 16-bit single-cycle CPU top. Each enabled cycle it captures the retired-instruction trace: PC, instruction word, ALU result and the zero, branch and mem-read flags.
- Records are buffered in a FIFO and streamed out as 16-bit words over a valid/ready link (debug UART or logic-analyser bridge).
- Overflow drops are counted; the CPU is never stalled.

Parameters:
- DEPTH, 16, FIFO depth in records; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH).
- SYNC_BYTE, 8'hA5, marker in header bits [15:8].

Ports:
- clk  in  1  system clock, same clock as the CPU.
- reset  in  1  asynchronous, active-low reset.
- trace_en  in  1  capture enable; sampled each rising edge.
- pc_in  in  16  program counter of the executing instruction.
- instr_in  in  16  instruction-memory output.
- alu_in  in  16  ALU result.
- zero_in  in  1  ALU zero flag.
- branch_in  in  1  branch control bit.
- mem_read_in  in  1  data-memory read strobe.
- clear_stats  in  1  synchronous clear of drop_count and overflow.
- out_data  out  16  stream word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the word when out_valid and out_ready are both high.
- fifo_level  out  ADDR_W+1  records stored in the FIFO (excludes the shadow record).
- overflow  out  1  sticky: at least one record dropped.
- drop_count  out  16  dropped records; saturates at 16'hFFFF.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and level are 0; serializer is in IDLE.
  - out_valid=0 and out_data=0.
  - overflow=0, drop_count=0, sequence counter=0.
- Capture:
  - On a rising edge with trace_en=1, the record {seq[3:0], zero, branch, mem_read, pc, instr, alu} is pushed, then seq increments (wraps 15 to 0).
  - If the FIFO is full and no pop happens in the same cycle, the record is dropped: seq does not increment, overflow is set, drop_count increments (saturating).
  - Push and pop in the same cycle while full: both succeed and the level is unchanged.
- Serializer FSM: IDLE, HDR, PC, INS, ALU.
  - IDLE: if fifo_level > 0, pop into the shadow register and go to HDR. Otherwise stay.
  - HDR: out_data = {SYNC_BYTE, ovf_flag, zero, branch, mem_read, seq}. ovf_flag is 1 if a drop occurred since the previous record was popped; it is latched at pop and the internal pending-drop bit clears at pop.
  - PC: out_data = pc. INS: out_data = instr. ALU: out_data = alu.
  - out_valid=1 in HDR, PC, INS and ALU. Each state advances only on out_valid & out_ready. out_data is held stable while the word is stalled.
  - Leaving ALU on a handshake: if fifo_level > 0, pop and go straight to HDR (back-to-back, no gap). Otherwise go to IDLE.
- Latency:
  - A record captured at edge k with the FIFO empty and the serializer in IDLE gives out_valid=1 after edge k+1.
  - With out_ready held at 1, one record takes 4 cycles. Sustained throughput is 1 record per 4 cycles.
- clear_stats:
  - Zeroes drop_count, overflow and the pending-drop bit.
  - If a drop occurs in the same cycle, clear wins: the counter is 0 afterwards.
  - FIFO contents are unaffected.
- fifo_level counts from 0 to DEPTH; the pointers wrap modulo DEPTH.
- Reset asserted mid-stream aborts the current record. After release, streaming resumes only with newly captured records.

Decomposition:
- Package trace_pkg holds:
  - the serializer state enum (3-bit);
  - the SYNC_BYTE default;
  - header bit positions (SYNC [15:8], OVF 7, Z 6, BR 5, MR 4, SEQ [3:0]);
  - record width constant REC_W = 55.
- Sub-module trace_fifo: a synchronous FIFO of REC_W-bit records with push, pop, full, empty and level outputs. Push-when-full is allowed only together with a pop.

Test Plan:
- Single capture: pc=16'h0010, instr=16'h1234, alu=16'h0042, zero=1, others 0, out_ready=1. Expect 16'hA540, 16'h0010, 16'h1234, 16'h0042 on consecutive cycles, starting one cycle after capture.
- Back-to-back: capture 3 records on consecutive cycles. Expect 12 words with no out_valid gap and headers seq 0, 1, 2.
- Backpressure: out_ready=0 for 5 cycles mid-record during PC. out_data stays 16'h0010 and the state does not advance; resumes correctly when ready returns.
- Overflow: DEPTH=16, out_ready=0, trace_en=1 for 20 cycles. Expect fifo_level=16, drop_count=3 (the shadow register holds 1 record), overflow=1. The header of the record popped after the drops has bit 7 set.
- clear_stats asserted in the same cycle as a drop: drop_count=0 and overflow=0 afterwards; the FIFO level is unchanged.
- Assert reset during the INS word: out_valid=0 immediately (asynchronously), fifo_level=0. After release, a new capture streams with seq=0.
